// File: rtl/pps_led_gen_if.sv
// Configuration write port of pps_led_gen: one strobe carrying a channel
// number, mode, period and duty fraction.
interface pps_led_gen_if #(
    parameter int NCH    = 4,
    parameter int DIV_W  = 26,
    parameter int DUTY_W = 8
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [DIV_W-1:0]  cfg_period;
    logic [DUTY_W-1:0] cfg_duty;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
endinterface

// File: rtl/pps_led_gen.sv
// Multi-channel LED / pulse generator with a 1 Hz base tick and an external
// PPS input that realigns every running channel and the tick counter.
module pps_led_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NCH    = 4,
    parameter int DIV_W  = 26,
    parameter int DUTY_W = 8
) (
    input  logic           CLK50M,
    input  logic           RSTN,
    pps_led_gen_if.slave   cfg_bus,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    output logic [NCH-1:0] led,
    output logic [NCH-1:0] pulse,
    output logic           tick
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = DIV_W + DUTY_W + 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic             r_sync_ff1, r_sync_ff2, r_sync_d;
    logic             w_sync_edge;
    logic [DIV_W-1:0] r_tick_cnt;
    logic             r_tick;
    logic [PW-1:0]    w_prod;
    logic [DIV_W:0]   w_t_new;
    logic [DUTY_W-1:0] w_unused_frac;

    always_ff @(posedge CLK50M or negedge RSTN) begin
        if (!RSTN) begin
            r_sync_ff1 <= 1'b0;
            r_sync_ff2 <= 1'b0;
            r_sync_d   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make this a true 3-stage shift; blocking ones would collapse it.
            r_sync_ff1 <= sync;
            r_sync_ff2 <= r_sync_ff1;
            r_sync_d   <= r_sync_ff2;
        end
    end

    assign w_sync_edge = r_sync_ff2 & ~r_sync_d;

    always_ff @(posedge CLK50M or negedge RSTN) begin
        if (!RSTN) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= (r_tick_cnt == '0);
            if (w_sync_edge || r_tick_cnt == DIV_W'(CLK_HZ - 1)) r_tick_cnt <= '0;
            else                                                r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign tick = r_tick;

    // Full-width product so the duty fraction is never truncated before the shift.
    assign w_prod        = (PW'(cfg_bus.cfg_period) + PW'(1)) * PW'(cfg_bus.cfg_duty);
    assign w_unused_frac = w_prod[DUTY_W-1:0];

    always_comb begin
        // NOTE: default first so every path assigns w_t_new and no latch is inferred.
        w_t_new = '0;
        case (mode_e'(cfg_bus.cfg_mode))
            MODE_BLINK:   w_t_new = ({1'b0, cfg_bus.cfg_period} + (DIV_W+1)'(1)) >> 1;
            MODE_PWM: begin
                w_t_new = w_prod[PW-1:DUTY_W];
                // A single-clock PWM period at half duty or more is held fully on.
                if (cfg_bus.cfg_period == '0 && cfg_bus.cfg_duty[DUTY_W-1]) w_t_new = (DIV_W+1)'(1);
            end
            MODE_ONESHOT: w_t_new = w_prod[PW-1:DUTY_W];
            default:      w_t_new = '0;
        endcase
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam mode_e            RST_MODE = (gi == 0) ? MODE_BLINK : MODE_OFF;
        localparam logic [DIV_W-1:0] RST_P    = (gi == 0) ? DIV_W'(CLK_HZ - 1) : '0;
        localparam logic [DIV_W:0]   RST_T    = (gi == 0) ? (DIV_W+1)'(CLK_HZ / 2) : '0;

        mode_e            r_mode;
        logic [DIV_W-1:0] r_p, r_c;
        logic [DIV_W:0]   r_t;
        logic             r_done, r_led, r_pulse;
        logic             w_hit, w_active;

        assign w_hit    = cfg_bus.cfg_we && (cfg_bus.cfg_ch == CH_W'(gi));
        assign w_active = en[gi] && (r_mode != MODE_OFF);

        // A restart edge (write or sync) drives both outputs low so the following
        // period start is the only pulse, even when both restart sources coincide.
        always_ff @(posedge CLK50M or negedge RSTN) begin
            if (!RSTN) begin
                r_mode  <= RST_MODE;
                r_p     <= RST_P;
                r_t     <= RST_T;
                r_c     <= '0;
                r_done  <= 1'b0;
                r_led   <= 1'b0;
                r_pulse <= 1'b0;
            end else if (w_hit) begin
                r_mode  <= mode_e'(cfg_bus.cfg_mode);
                r_p     <= cfg_bus.cfg_period;
                r_t     <= w_t_new;
                r_c     <= '0;
                r_done  <= 1'b0;
                r_led   <= 1'b0;
                r_pulse <= 1'b0;
            end else if (!w_active || w_sync_edge) begin
                r_c     <= '0;
                r_done  <= 1'b0;
                r_led   <= 1'b0;
                r_pulse <= 1'b0;
            end else if (r_mode == MODE_ONESHOT && r_done) begin
                r_led   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_led   <= ({1'b0, r_c} < r_t);
                r_pulse <= (r_c == '0);
                if (r_c == r_p) begin
                    r_c    <= (r_mode == MODE_ONESHOT) ? r_c : '0;
                    r_done <= (r_mode == MODE_ONESHOT);
                end else begin
                    r_c    <= r_c + 1'b1;
                end
            end
        end

        assign led[gi]   = r_led;
        assign pulse[gi] = r_pulse;
    end
endmodule

// File: tb/tb_pps_led_gen.sv
// Scoreboard bench for pps_led_gen: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pps_led_gen;
    localparam int CLK_HZ = 10;
    localparam int NCH    = 4;
    localparam int DIV_W  = 8;
    localparam int DUTY_W = 4;

    typedef struct {
        int         cyc;
        logic [8:0] exp;
        logic [8:0] mask;
        string      tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [NCH-1:0] en = '1;
    logic           sync = 1'b0;
    logic [NCH-1:0] led, pulse;
    logic           tick;
    int             cyc = 0;
    int             n_chk = 0;
    int             n_err = 0;
    exp_t           q[$];

    pps_led_gen_if #(.NCH(NCH), .DIV_W(DIV_W), .DUTY_W(DUTY_W)) cfg_if ();

    pps_led_gen #(.CLK_HZ(CLK_HZ), .NCH(NCH), .DIV_W(DIV_W), .DUTY_W(DUTY_W)) dut (
        .CLK50M  (clk),
        .RSTN    (rstn),
        .cfg_bus (cfg_if.slave),
        .en      (en),
        .sync    (sync),
        .led     (led),
        .pulse   (pulse),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(string tag, logic [8:0] act, logic [8:0] exp, logic [8:0] mask);
        n_chk++;
        if (((act ^ exp) & mask) !== 9'b0) begin
            n_err++;
            $display("FAIL %s: got led=%b pulse=%b tick=%b, want led=%b pulse=%b tick=%b (mask %b)",
                     tag, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0], mask);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL %s@%0d: expectation missed, now at edge %0d", e.tag, e.cyc, cyc);
            end else begin
                check($sformatf("%s@%0d", e.tag, e.cyc), {led, pulse, tick}, e.exp, e.mask);
            end
        end
    end

    task automatic push(int c, logic [3:0] lm, logic [3:0] le, logic [3:0] pm, logic [3:0] pe,
                        logic tm, logic te, string tag);
        exp_t e;
        e.cyc  = c;
        e.exp  = {le, pe, te};
        e.mask = {lm, pm, tm};
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic wait_until(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic cfg_write(int ch, int mode, int period, int duty);
        cfg_if.cfg_we     = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_mode   = 2'(mode);
        cfg_if.cfg_period = 8'(period);
        cfg_if.cfg_duty   = 4'(duty);
        @(negedge clk);
        cfg_if.cfg_we     = 1'b0;
    endtask

    // 1 Hz / 50 % channel-0 pattern and aligned tick from a reset release.
    task automatic push_pps(int first, int last);
        logic [3:0] l, p;
        for (int n = first; n <= last; n++) begin
            l = '0;
            p = '0;
            l[0] = ((n - 1) % 10) < 5;
            p[0] = ((n - 1) % 10) == 0;
            push(n, 4'hF, l, 4'hF, p, 1'b1, p[0], "pps0");
        end
    endtask

    // Single-channel period pattern starting at edge s (restart edge s-1 is all zero).
    task automatic push_ch(int ch, int s, int last, int per, int thr, bit once, string tag);
        logic [3:0] l, p, mk;
        int         m;
        mk = 4'(1 << ch);
        push(s - 1, mk, 4'h0, mk, 4'h0, 1'b0, 1'b0, {tag, "_wr"});
        for (int n = s; n <= last; n++) begin
            m = once ? (n - s) : ((n - s) % per);
            l = '0;
            p = '0;
            l[ch] = (m < thr);
            p[ch] = (m == 0);
            push(n, mk, l, mk, p, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        logic [3:0] l, p;
        int         guard;
        cfg_if.cfg_we     = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mode   = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        push(0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, "in_reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        push_pps(1, 30);
        wait_until(30);

        // ch1 PWM: P=7, duty 4/16 -> T=2.
        push_ch(1, 32, 50, 8, 2, 1'b0, "pwm1");
        cfg_write(1, 2, 7, 4);
        wait_until(50);

        // ch2 one-shot: P=5, duty 8/16 -> T=3; write, rewrite, en toggle.
        push_ch(2, 52, 66, 6, 3, 1'b1, "shot2a");
        cfg_write(2, 3, 5, 8);
        wait_until(66);
        push_ch(2, 68, 77, 6, 3, 1'b1, "shot2b");
        cfg_write(2, 3, 5, 8);
        wait_until(77);
        push_ch(2, 79, 88, 6, 3, 1'b1, "shot2en");
        en[2] = 1'b0;
        @(negedge clk);
        en[2] = 1'b1;
        wait_until(88);

        // ch3 duty 0: pulse every 4, led never; then disabled.
        push_ch(3, 90, 100, 4, 0, 1'b0, "duty0_3");
        cfg_write(3, 2, 3, 0);
        wait_until(100);
        for (int n = 101; n <= 106; n++) push(n, 4'h8, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0, "en3off");
        en[3] = 1'b0;
        wait_until(106);

        // ch3 PWM P=0 at half duty: led held high, pulse every edge.
        push_ch(3, 108, 115, 1, 1, 1'b0, "p0half3");
        en[3] = 1'b1;
        cfg_write(3, 2, 0, 8);
        wait_until(115);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end

        // Mid-period reset while led[3] is high.
        @(posedge clk);
        #2;
        rstn = 1'b0;
        push(0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, "mid_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_pps(1, 12);

        // sync reaches first flop at edge 15 (tick count 4); realign at edge 18,
        // with a ch1 write landing on the sync-detect edge 17.
        for (int n = 15; n <= 30; n++) begin
            l = '0;
            p = '0;
            if (n < 17)       l[0] = ((n - 1) % 10) < 5;
            else if (n >= 18) begin
                l[0] = ((n - 18) % 10) < 5;
                l[1] = ((n - 18) % 8) < 2;
            end
            p[0] = (n == 18) || (n == 28);
            p[1] = (n == 18) || (n == 26);
            push(n, 4'h3, l, 4'h3, p, 1'b1, p[0], "sync");
        end
        wait_until(14);
        sync = 1'b1;
        wait_until(16);
        cfg_write(1, 2, 7, 4);
        wait_until(20);
        sync = 1'b0;
        wait_until(30);
        @(negedge clk);

        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        n_chk++;
        n_err++;
        $display("FAIL watchdog: edge %0d reached time limit, want completion", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
